// File: rtl/mult_diya_fp32.sv
// -----------------------------------------------------------------------------
// mult_diya_fp32
//   IEEE-754 binary32 multiplier, round-to-nearest-even, one register stage.
//   Subnormal operands are read as signed zero, and subnormal results are
//   flushed to signed zero. NaN payloads are propagated and quieted.
//
// Ports
//   clk        in   1   system clock, rising edge
//   nRST       in   1   asynchronous active-low reset
//   valid_in   in   1   data1/data2 carry an operand pair this cycle
//   data1      in  32   operand A (binary32)
//   data2      in  32   operand B (binary32)
//   result     out 32   registered product (binary32), held while idle
//   valid_out  out  1   result holds the product of the previous cycle's pair
// -----------------------------------------------------------------------------
module mult_diya_fp32 (
   input  logic        clk,
   input  logic        nRST,
   input  logic        valid_in,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [31:0] result,
   output logic        valid_out
);

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   // Operand fields
   logic       sign_a, sign_b, sign_p;
   logic [7:0] exp_a, exp_b;
   logic [22:0] frac_a, frac_b;

   assign sign_a = data1[31];
   assign sign_b = data2[31];
   assign exp_a  = data1[30:23];
   assign exp_b  = data2[30:23];
   assign frac_a = data1[22:0];
   assign frac_b = data2[22:0];
   assign sign_p = sign_a ^ sign_b;

   // Operand classes. A zero exponent covers both true zero and subnormals,
   // which this unit treats as zero.
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
   assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
   assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
   assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
   assign a_zero = (exp_a == 8'd0);
   assign b_zero = (exp_b == 8'd0);

   // Finite datapath
   logic [47:0]        prod;
   logic               norm;
   logic [22:0]        mant;
   logic               guard_bit, round_bit, sticky_bit, round_up;
   logic [23:0]        mant_rnd;
   logic               rnd_carry;
   logic signed [9:0]  exp_final;
   logic [31:0]        finite_res;
   logic [31:0]        result_d;
   logic [31:0]        result_q;
   logic               valid_q;

   assign prod = {1'b1, frac_a} * {1'b1, frac_b};
   assign norm = prod[47];

   // NOTE: every signal assigned in always_comb gets a default on entry so
   // no path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      mant       = prod[45:23];
      guard_bit  = prod[22];
      round_bit  = prod[21];
      sticky_bit = |prod[20:0];
      if (norm) begin
         // Product in [2,4): take the leading one at bit 47 instead.
         mant       = prod[46:24];
         guard_bit  = prod[23];
         round_bit  = prod[22];
         sticky_bit = |prod[21:0];
      end
   end

   // Ties-to-even: on an exact half, round up only if the kept LSB is odd.
   assign round_up  = guard_bit & (round_bit | sticky_bit | mant[0]);
   assign mant_rnd  = {1'b0, mant} + {23'd0, round_up};
   // A carry out of the fraction means 1.111..1 rounded to 10.000..0; the
   // fraction bits are then already zero, so only the exponent moves.
   assign rnd_carry = mant_rnd[23];

   assign exp_final = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b})
                    - 10'sd127
                    + $signed({9'd0, norm})
                    + $signed({9'd0, rnd_carry});

   always_comb begin
      finite_res = {sign_p, exp_final[7:0], mant_rnd[22:0]};
      if (exp_final >= 10'sd255) begin
         finite_res = {sign_p, 8'hFF, 23'd0};
      end else if (exp_final <= 10'sd0) begin
         finite_res = {sign_p, 31'd0};
      end
   end

   // Special-case selection, highest priority first.
   always_comb begin
      result_d = finite_res;
      if (a_nan) begin
         result_d = data1 | 32'h0040_0000;
      end else if (b_nan) begin
         result_d = data2 | 32'h0040_0000;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         result_d = CANON_NAN;
      end else if (a_inf || b_inf) begin
         result_d = {sign_p, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         result_d = {sign_p, 31'd0};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other, independent of block order.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         result_q <= 32'h0000_0000;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= valid_in;
         if (valid_in) begin
            result_q <= result_d;
         end
      end
   end

   assign result    = result_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_mult_diya_fp32.sv
// -----------------------------------------------------------------------------
// tb_mult_diya_fp32
//   Directed vectors followed by random operand pairs compared against a
//   real-arithmetic reference model of the binary32 multiply.
// -----------------------------------------------------------------------------
module tb_mult_diya_fp32;

   logic        clk;
   logic        nRST;
   logic        valid_in;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] result;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   mult_diya_fp32 dut (
      .clk       (clk),
      .nRST      (nRST),
      .valid_in  (valid_in),
      .data1     (data1),
      .data2     (data2),
      .result    (result),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Magnitude of a finite binary32 value; subnormals read as zero.
   function automatic real to_real(input logic [31:0] x);
      real m;
      int  e;
      if (x[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return m;
   endfunction

   // Reference multiply: specials by rule, finite values by exact double
   // product (24x24 bits fits in 53) rounded half-to-even into binary32.
   function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      real    mag, scaled, ip_r, rem;
      longint ip;
      int     e, biased;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      if (a_nan) return a | 32'h0040_0000;
      if (b_nan) return b | 32'h0040_0000;
      if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      mag = to_real(a) * to_real(b);
      e = 0;
      while (mag >= 2.0) begin mag = mag / 2.0; e++; end
      while (mag < 1.0)  begin mag = mag * 2.0; e--; end
      scaled = mag * 8388608.0;
      ip_r   = $floor(scaled);
      rem    = scaled - ip_r;
      ip     = longint'(ip_r);
      if (rem > 0.5 || (rem == 0.5 && ip[0])) ip++;
      if (ip == 64'd16777216) begin ip = 64'd8388608; e++; end
      biased = e + 127;
      if (biased >= 255) return {s, 8'hFF, 23'd0};
      if (biased <= 0)   return {s, 31'd0};
      return {s, biased[7:0], ip[22:0]};
   endfunction

   // Present a pair for one edge and check the registered product after it.
   // Calls chain without idle cycles, so consecutive calls are back-to-back.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      data1    = a;
      data2    = b;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
      check(tag, result, exp);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      int          cls;
      r   = $urandom;
      cls = $urandom_range(0, 19);
      case (cls)
         0: r[30:0]  = 31'd0;                                  // signed zero
         1: r[30:0]  = {8'hFF, 23'd0};                         // infinity
         2: begin r[30:23] = 8'hFF; r[22] = $urandom_range(0, 1); if (r[22:0] == 0) r[0] = 1'b1; end
         3: begin r[30:23] = 8'd0; if (r[22:0] == 0) r[0] = 1'b1; end  // subnormal
         4, 5: r[30:23] = 8'($urandom_range(1, 254));          // full range
         default: r[30:23] = 8'($urandom_range(64, 190));      // mid range
      endcase
      return r;
   endfunction

   logic [31:0] held;
   logic [31:0] ra, rb;

   initial begin
      nRST     = 1'b0;
      valid_in = 1'b0;
      data1    = 32'd0;
      data2    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'd0, valid_out}, 32'd0);
      @(negedge clk);
      nRST = 1'b1;

      // Positive x positive
      issue("pos_100x90", 32'h42C8_6666, 32'h42B5_0000, 32'h460D_B066);
      issue("one_x_one",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);

      // Sign combinations, back-to-back
      issue("neg_neg", 32'hC0AC_CCCD, 32'hC12C_CCCD, 32'h4269_47AF);
      issue("pos_neg", 32'h40AC_CCCD, 32'hC12C_CCCD, 32'hC269_47AF);
      issue("neg_pos", 32'hC12C_CCCD, 32'h40AC_CCCD, 32'hC269_47AF);

      // NaN propagation
      issue("nan_b_all_ones", 32'h40AC_CCCD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue("nan_a_quiet",    32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0001);
      issue("nan_both_a_wins", 32'hFF80_0005, 32'h7FC0_1234, 32'hFFC0_0005);

      // Specials
      issue("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
      issue("zero_x_inf",  32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000);
      issue("ninf_x_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
      issue("inf_x_ninf",  32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000);
      issue("nzero_x_three", 32'h8000_0000, 32'h4040_0000, 32'h8000_0000);
      issue("subn_x_two",  32'h0000_0001, 32'hC000_0000, 32'h8000_0000);

      // Range limits and rounding
      issue("overflow",    32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
      issue("flush_zero",  32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
      issue("round_near",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
      issue("round_carry", 32'h3FFF_FFFF, 32'h3FFF_FFFF, model_mul(32'h3FFF_FFFF, 32'h3FFF_FFFF));

      // Idle: valid_out drops, result holds
      held     = result;
      valid_in = 1'b0;
      data1    = 32'h4040_0000;
      data2    = 32'h4040_0000;
      repeat (2) @(posedge clk);
      #1;
      check("idle_valid", {31'd0, valid_out}, 32'd0);
      check("idle_hold", result, held);

      // Random pairs against the reference model
      for (int i = 0; i < 300; i++) begin
         ra = rand_operand();
         rb = rand_operand();
         issue($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, model_mul(ra, rb));
      end

      // Reset mid-operation: asynchronous clear, held across an edge
      issue("pre_reset", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      #2;
      nRST = 1'b0;
      #1;
      check("async_reset_result", result, 32'h0);
      check("async_reset_valid", {31'd0, valid_out}, 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold_result", result, 32'h0);
      check("reset_hold_valid", {31'd0, valid_out}, 32'd0);
      @(negedge clk);
      nRST     = 1'b1;
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("post_reset_valid", {31'd0, valid_out}, 32'd0);
      check("post_reset_result", result, 32'h0);
      issue("post_reset_mul", 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
